s0_avmm_slave_responder: RTL and testbench

Avalon-MM slave responder that terminates the AVMM master driven by sector-0 PR user logic on the static-region side of the PR boundary. It provides a control/status register bank and a scratch word memory, and returns read data with a fixed, pipelined latency. It holds off the master through `avmm_slave_waitrequest` while the static region freezes the PR interface during reconfiguration.

---
 rtl/s0_avmm_slave_responder.sv | 197 +++++++++++++++++++
 tb/tb_s0_avmm_slave_responder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s0_avmm_slave_responder.sv
// s0_avmm_slave_responder: static-side AVMM slave for sector-0 PR user logic.
// CSR bank + scratch RAM; `S0_AVMM_PERF_CNT_EN adds WR/RD counters.
module s0_avmm_slave_responder #(
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned MEM_DEPTH = 256,
  parameter logic [31:0] ID_VALUE  = 32'h5EC7_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [19:0] avmm_slave_address,
  input  logic        avmm_slave_read,
  input  logic        avmm_slave_write,
  input  logic [31:0] avmm_slave_writedata,
  input  logic [3:0]  avmm_slave_byteenable,
  output logic        avmm_slave_waitrequest,
  output logic [31:0] avmm_slave_readdata,
  output logic        avmm_slave_readdatavalid,
  output logic [7:0]  ctrl_out,
  output logic [1:0]  err_out
);

  localparam int unsigned AW =
    (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [17:0] MEM_LO = 18'h00400;
  localparam logic [17:0] MEM_HI = MEM_LO + 18'(MEM_DEPTH);

  logic [17:0]   word;
  logic [1:0]    unused_byte;
  logic [AW-1:0] mem_idx;

  assign word        = avmm_slave_address[19:2];
  assign unused_byte = avmm_slave_address[1:0];
  assign mem_idx     = word[AW-1:0];

  logic wait_q;
  logic accept;
  logic rd_acc;
  logic wr_acc;
  logic both;

  assign accept = (avmm_slave_read | avmm_slave_write)
                & ~wait_q;
  assign rd_acc = accept & avmm_slave_read
                & ~avmm_slave_write;
  assign wr_acc = accept & avmm_slave_write;
  assign both   = accept & avmm_slave_read
                & avmm_slave_write;

  logic hit_id;
  logic hit_scr;
  logic hit_ctrl;
  logic hit_err;
  logic hit_mem;
  logic hit_cnt;
  logic unmapped;

  assign hit_id   = word == 18'h0;
  assign hit_scr  = word == 18'h1;
  assign hit_ctrl = word == 18'h2;
  assign hit_err  = word == 18'h3;
  assign hit_mem  = (word >= MEM_LO) && (word < MEM_HI);

`ifdef S0_AVMM_PERF_CNT_EN
  logic        hit_wrc;
  logic        hit_rdc;
  logic [31:0] wrc_q;
  logic [31:0] rdc_q;

  assign hit_wrc = word == 18'h4;
  assign hit_rdc = word == 18'h5;
  assign hit_cnt = hit_wrc | hit_rdc;
`else
  assign hit_cnt = 1'b0;
`endif

  assign unmapped = ~(hit_id | hit_scr | hit_ctrl
                    | hit_err | hit_mem | hit_cnt);

  logic [31:0] scratch_q, scratch_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] mem_q [MEM_DEPTH];
  logic [31:0] rdata_d;

  always_comb begin
    rdata_d = 32'hDEAD_BEEF;
    unique case (1'b1)
      hit_id:   rdata_d = ID_VALUE;
      hit_scr:  rdata_d = scratch_q;
      hit_ctrl: rdata_d = {24'h0, ctrl_q};
      hit_err:  rdata_d = {30'h0, err_q};
      hit_mem:  rdata_d = mem_q[mem_idx];
`ifdef S0_AVMM_PERF_CNT_EN
      hit_wrc:  rdata_d = wrc_q;
      hit_rdc:  rdata_d = rdc_q;
`endif
      default:  ;
    endcase
  end

  always_comb begin
    scratch_d = scratch_q;
    ctrl_d    = ctrl_q;
    err_d     = err_q;
    if (wr_acc) begin
      if (hit_scr) begin
        for (int b = 0; b < 4; b++) begin
          if (avmm_slave_byteenable[b]) begin
            scratch_d[8*b +: 8] =
              avmm_slave_writedata[8*b +: 8];
          end
        end
      end
      if (hit_ctrl && avmm_slave_byteenable[0]) begin
        ctrl_d = avmm_slave_writedata[7:0];
      end
      if (hit_err && avmm_slave_byteenable[0]) begin
        err_d = err_q & ~avmm_slave_writedata[1:0];
      end
    end
    // set conditions applied last so they beat a same-cycle clear
    if (accept && unmapped) err_d[0] = 1'b1;
    if (both) err_d[1] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q    <= 1'b1;
      scratch_q <= '0;
      ctrl_q    <= '0;
      err_q     <= '0;
    end else begin
      wait_q    <= freeze;
      scratch_q <= scratch_d;
      ctrl_q    <= ctrl_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && hit_mem) begin
      for (int b = 0; b < 4; b++) begin
        if (avmm_slave_byteenable[b]) begin
          mem_q[mem_idx][8*b +: 8] <=
            avmm_slave_writedata[8*b +: 8];
        end
      end
    end
  end

`ifdef S0_AVMM_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrc_q <= '0;
      rdc_q <= '0;
    end else begin
      if (wr_acc && hit_wrc) begin
        wrc_q <= '0;
      end else if (wr_acc && !hit_cnt) begin
        wrc_q <= wrc_q + 32'd1;
      end
      if (wr_acc && hit_rdc) begin
        rdc_q <= '0;
      end else if (rd_acc) begin
        rdc_q <= rdc_q + 32'd1;
      end
    end
  end
`endif

  // stage 0 captures at accept; the last stage drives the bus
  logic [READ_LAT:0] vld_q;
  logic [31:0]       dat_q [READ_LAT+1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i <= int'(READ_LAT); i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q    <= {vld_q[READ_LAT-1:0], rd_acc};
      dat_q[0] <= rdata_d;
      for (int i = 1; i <= int'(READ_LAT); i++) begin
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign avmm_slave_waitrequest   = wait_q;
  assign avmm_slave_readdata      = dat_q[READ_LAT];
  assign avmm_slave_readdatavalid = vld_q[READ_LAT];
  assign ctrl_out                 = ctrl_q;
  assign err_out                  = err_q;

endmodule

// File: tb/tb_s0_avmm_slave_responder.sv
// tb_s0_avmm_slave_responder: scoreboard bench for s0_avmm_slave_responder.
// Define S0_AVMM_PERF_CNT_EN for both files to cover the counters.
module tb_s0_avmm_slave_responder;
  localparam int LAT = 2;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;
  localparam logic [31:0] IDV = 32'h5EC7_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic [19:0] addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  ben = '0;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic [7:0]  ctrl_out;
  logic [1:0]  err_out;

  typedef struct {
    logic [31:0] d;
    int          c;
  } ent_t;

  ent_t exp_q[$];
  ent_t rsp_q[$];
  int cyc = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  s0_avmm_slave_responder #(
    .READ_LAT(LAT), .MEM_DEPTH(256), .ID_VALUE(IDV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .freeze(freeze),
    .avmm_slave_address(addr),
    .avmm_slave_read(rd),
    .avmm_slave_write(wr),
    .avmm_slave_writedata(wdata),
    .avmm_slave_byteenable(ben),
    .avmm_slave_waitrequest(waitrequest),
    .avmm_slave_readdata(readdata),
    .avmm_slave_readdatavalid(readdatavalid),
    .ctrl_out(ctrl_out),
    .err_out(err_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (readdatavalid === 1'b1)
      rsp_q.push_back('{d: readdata, c: cyc});

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic xfer(input logic r, input logic w,
                      input logic [19:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [31:0] ex);
    int n;
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d; ben = be;
    n = 0;
    while (waitrequest !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      fail_cnt++;
      $display("FAIL xfer_accept addr=%h waitrequest=%b, required 0", a, waitrequest);
    end else begin
      @(posedge clk);
      #1;
      if (r && !w) exp_q.push_back('{d: ex, c: cyc});
    end
  endtask

  task automatic idle();
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    #1;
  endtask

  task automatic wait_rsp(output bit ok);
    int n = 0;
    while (rsp_q.size() < exp_q.size() && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (LAT + 3) @(negedge clk);
    #1;
    ok = (rsp_q.size() == exp_q.size());
  endtask

  task automatic test_reset();
    ent_t e, r;
    bit ok;
    repeat (2) @(negedge clk);
    #1;
    if (waitrequest !== 1'b1) begin fail_cnt++; $display("FAIL rst_wait got %b, required 1", waitrequest); end else pass_cnt++;
    if (readdatavalid !== 1'b0) begin fail_cnt++; $display("FAIL rst_rdv got %b, required 0", readdatavalid); end else pass_cnt++;
    if (readdata !== 32'h0) begin fail_cnt++; $display("FAIL rst_rdata got %h, required 0", readdata); end else pass_cnt++;
    if (ctrl_out !== 8'h0) begin fail_cnt++; $display("FAIL rst_ctrl got %h, required 0", ctrl_out); end else pass_cnt++;
    if (err_out !== 2'b00) begin fail_cnt++; $display("FAIL rst_err got %b, required 00", err_out); end else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    if (waitrequest !== 1'b0) begin fail_cnt++; $display("FAIL rel_wait got %b, required 0", waitrequest); end else pass_cnt++;
    xfer(1, 0, 20'h00000, 0, 4'hF, IDV);
    idle();
    wait_rsp(ok);
    if (!ok) begin fail_cnt++; $display("FAIL id_count got %0d, required %0d", rsp_q.size(), exp_q.size()); end else pass_cnt++;
    while (exp_q.size() > 0 && rsp_q.size() > 0) begin
      e = exp_q.pop_front(); r = rsp_q.pop_front();
      if (r.d !== e.d || r.c - e.c != LAT) begin fail_cnt++; $display("FAIL id_rsp got %h lat %0d, required %h lat %0d", r.d, r.c - e.c, e.d, LAT); end else pass_cnt++;
    end
    exp_q.delete(); rsp_q.delete();
  endtask

  task automatic test_scratch();
    ent_t e, r;
    bit ok;
    xfer(1, 0, 20'h00004, 0, 4'hF, 32'h0);
    xfer(0, 1, 20'h00004, 32'hA5A5_A5A5, 4'b0011, 0);
    xfer(1, 0, 20'h00004, 0, 4'hF, 32'h0000_A5A5);
    xfer(0, 1, 20'h00008, 32'hFFFF_FF3C, 4'hF, 0);
    xfer(0, 1, 20'h00008, 32'h0000_0077, 4'b1110, 0);
    xfer(1, 0, 20'h00008, 0, 4'hF, 32'h0000_003C);
    xfer(0, 1, 20'h00000, 32'hFFFF_FFFF, 4'hF, 0);
    xfer(1, 0, 20'h00000, 0, 4'hF, IDV);
    idle();
    wait_rsp(ok);
    if (!ok) begin fail_cnt++; $display("FAIL scr_count got %0d, required %0d", rsp_q.size(), exp_q.size()); end else pass_cnt++;
    while (exp_q.size() > 0 && rsp_q.size() > 0) begin
      e = exp_q.pop_front(); r = rsp_q.pop_front();
      if (r.d !== e.d || r.c - e.c != LAT) begin fail_cnt++; $display("FAIL scr_rsp got %h lat %0d, required %h lat %0d", r.d, r.c - e.c, e.d, LAT); end else pass_cnt++;
    end
    exp_q.delete(); rsp_q.delete();
    if (ctrl_out !== 8'h3C) begin fail_cnt++; $display("FAIL ctrl_out got %h, required 3c", ctrl_out); end else pass_cnt++;
    if (err_out !== 2'b00) begin fail_cnt++; $display("FAIL id_wr_err got %b, required 00", err_out); end else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    ent_t e, r;
    bit ok;
    int prevc;
    for (int i = 0; i < 8; i++)
      xfer(0, 1, 20'h01000 + 20'(4 * i), 32'h100 + 32'(i), 4'hF, 0);
    xfer(0, 1, 20'h013FC, 32'hCAFE_F00D, 4'hF, 0);
    for (int i = 0; i < 8; i++)
      xfer(1, 0, 20'h01000 + 20'(4 * i), 0, 4'hF, 32'h100 + 32'(i));
    xfer(1, 0, 20'h013FC, 0, 4'hF, 32'hCAFE_F00D);
    idle();
    wait_rsp(ok);
    if (!ok) begin fail_cnt++; $display("FAIL b2b_count got %0d, required %0d", rsp_q.size(), exp_q.size()); end else pass_cnt++;
    prevc = -1;
    while (exp_q.size() > 0 && rsp_q.size() > 0) begin
      e = exp_q.pop_front(); r = rsp_q.pop_front();
      if (r.d !== e.d || r.c - e.c != LAT) begin fail_cnt++; $display("FAIL b2b_rsp got %h lat %0d, required %h lat %0d", r.d, r.c - e.c, e.d, LAT); end else pass_cnt++;
      if (prevc >= 0) begin
        if (r.c != prevc + 1) begin fail_cnt++; $display("FAIL b2b_gap got cycle %0d, required %0d", r.c, prevc + 1); end else pass_cnt++;
      end
      prevc = r.c;
    end
    exp_q.delete(); rsp_q.delete();
  endtask

  task automatic test_err();
    ent_t e, r;
    bit ok;
    xfer(1, 0, 20'h00800, 0, 4'hF, BAD);
    idle();
    if (err_out !== 2'b01) begin fail_cnt++; $display("FAIL err_unmap_rd got %b, required 01", err_out); end else pass_cnt++;
    xfer(0, 1, 20'h0000C, 32'h1, 4'hF, 0);
    idle();
    if (err_out !== 2'b00) begin fail_cnt++; $display("FAIL err_clr0 got %b, required 00", err_out); end else pass_cnt++;
    xfer(0, 1, 20'h01400, 32'h11, 4'hF, 0);
    xfer(1, 0, 20'h01400, 0, 4'hF, BAD);
    idle();
    if (err_out !== 2'b01) begin fail_cnt++; $display("FAIL err_unmap_wr got %b, required 01", err_out); end else pass_cnt++;
    xfer(0, 1, 20'h0000C, 32'h1, 4'hF, 0);
    xfer(1, 1, 20'h00004, 32'h1234_5678, 4'hF, 0);
    idle();
    if (err_out !== 2'b10) begin fail_cnt++; $display("FAIL err_rw got %b, required 10", err_out); end else pass_cnt++;
    xfer(1, 0, 20'h00004, 0, 4'hF, 32'h1234_5678);
    xfer(1, 1, 20'h0000C, 32'h2, 4'hF, 0);
    idle();
    if (err_out !== 2'b10) begin fail_cnt++; $display("FAIL err_setwins got %b, required 10", err_out); end else pass_cnt++;
    xfer(0, 1, 20'h0000C, 32'h2, 4'hF, 0);
    idle();
    if (err_out !== 2'b00) begin fail_cnt++; $display("FAIL err_clr1 got %b, required 00", err_out); end else pass_cnt++;
    wait_rsp(ok);
    if (!ok) begin fail_cnt++; $display("FAIL err_count got %0d, required %0d", rsp_q.size(), exp_q.size()); end else pass_cnt++;
    while (exp_q.size() > 0 && rsp_q.size() > 0) begin
      e = exp_q.pop_front(); r = rsp_q.pop_front();
      if (r.d !== e.d || r.c - e.c != LAT) begin fail_cnt++; $display("FAIL err_rsp got %h lat %0d, required %h lat %0d", r.d, r.c - e.c, e.d, LAT); end else pass_cnt++;
    end
    exp_q.delete(); rsp_q.delete();
  endtask

  task automatic test_freeze();
    ent_t e, r;
    bit ok;
    int bad;
    xfer(1, 0, 20'h01000, 0, 4'hF, 32'h100);
    xfer(1, 0, 20'h01004, 0, 4'hF, 32'h101);
    @(negedge clk);
    rd = 1'b0; freeze = 1'b1;
    @(posedge clk);
    #1;
    if (waitrequest !== 1'b1) begin fail_cnt++; $display("FAIL frz_wait got %b, required 1", waitrequest); end else pass_cnt++;
    @(negedge clk);
    rd = 1'b1; addr = 20'h00000;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (waitrequest !== 1'b1) bad++;
    end
    if (bad != 0) begin fail_cnt++; $display("FAIL frz_hold got %0d open cycles, required 0", bad); end else pass_cnt++;
    wait_rsp(ok);
    if (!ok) begin fail_cnt++; $display("FAIL frz_count got %0d, required %0d", rsp_q.size(), exp_q.size()); end else pass_cnt++;
    while (exp_q.size() > 0 && rsp_q.size() > 0) begin
      e = exp_q.pop_front(); r = rsp_q.pop_front();
      if (r.d !== e.d || r.c - e.c != LAT) begin fail_cnt++; $display("FAIL frz_rsp got %h lat %0d, required %h lat %0d", r.d, r.c - e.c, e.d, LAT); end else pass_cnt++;
    end
    exp_q.delete(); rsp_q.delete();
    freeze = 1'b0;
    xfer(1, 0, 20'h00000, 0, 4'hF, IDV);
    idle();
    wait_rsp(ok);
    if (!ok) begin fail_cnt++; $display("FAIL unfrz_count got %0d, required %0d", rsp_q.size(), exp_q.size()); end else pass_cnt++;
    while (exp_q.size() > 0 && rsp_q.size() > 0) begin
      e = exp_q.pop_front(); r = rsp_q.pop_front();
      if (r.d !== e.d || r.c - e.c != LAT) begin fail_cnt++; $display("FAIL unfrz_rsp got %h lat %0d, required %h lat %0d", r.d, r.c - e.c, e.d, LAT); end else pass_cnt++;
    end
    exp_q.delete(); rsp_q.delete();
  endtask

`ifdef S0_AVMM_PERF_CNT_EN
  task automatic test_perf();
    ent_t e, r;
    bit ok;
    xfer(0, 1, 20'h00014, 0, 4'hF, 0);
    xfer(0, 1, 20'h00010, 0, 4'hF, 0);
    for (int i = 0; i < 3; i++)
      xfer(0, 1, 20'h00004, 32'h55 + 32'(i), 4'hF, 0);
    for (int i = 0; i < 4; i++)
      xfer(1, 0, 20'h00004, 0, 4'hF, 32'h57);
    xfer(1, 0, 20'h00010, 0, 4'hF, 32'd3);
    xfer(1, 0, 20'h00014, 0, 4'hF, 32'd5);
    xfer(0, 1, 20'h00010, 32'hFFFF_FFFF, 4'hF, 0);
    xfer(1, 0, 20'h00010, 0, 4'hF, 32'd0);
    idle();
    wait_rsp(ok);
    if (!ok) begin fail_cnt++; $display("FAIL perf_count got %0d, required %0d", rsp_q.size(), exp_q.size()); end else pass_cnt++;
    while (exp_q.size() > 0 && rsp_q.size() > 0) begin
      e = exp_q.pop_front(); r = rsp_q.pop_front();
      if (r.d !== e.d || r.c - e.c != LAT) begin fail_cnt++; $display("FAIL perf_rsp got %h lat %0d, required %h lat %0d", r.d, r.c - e.c, e.d, LAT); end else pass_cnt++;
    end
    exp_q.delete(); rsp_q.delete();
    if (err_out !== 2'b00) begin fail_cnt++; $display("FAIL perf_err got %b, required 00", err_out); end else pass_cnt++;
  endtask
`else
  task automatic test_perf();
    ent_t e, r;
    bit ok;
    xfer(1, 0, 20'h00010, 0, 4'hF, BAD);
    xfer(1, 0, 20'h00014, 0, 4'hF, BAD);
    idle();
    if (err_out !== 2'b01) begin fail_cnt++; $display("FAIL nocnt_err got %b, required 01", err_out); end else pass_cnt++;
    xfer(0, 1, 20'h0000C, 32'h1, 4'hF, 0);
    idle();
    wait_rsp(ok);
    if (!ok) begin fail_cnt++; $display("FAIL nocnt_count got %0d, required %0d", rsp_q.size(), exp_q.size()); end else pass_cnt++;
    while (exp_q.size() > 0 && rsp_q.size() > 0) begin
      e = exp_q.pop_front(); r = rsp_q.pop_front();
      if (r.d !== e.d || r.c - e.c != LAT) begin fail_cnt++; $display("FAIL nocnt_rsp got %h lat %0d, required %h lat %0d", r.d, r.c - e.c, e.d, LAT); end else pass_cnt++;
    end
    exp_q.delete(); rsp_q.delete();
  endtask
`endif

  task automatic test_reset_mid();
    ent_t e, r;
    bit ok;
    xfer(0, 1, 20'h00008, 32'h5A, 4'hF, 0);
    xfer(1, 0, 20'h00800, 0, 4'hF, BAD);
    xfer(1, 0, 20'h01000, 0, 4'hF, 32'h100);
    @(negedge clk);
    rd = 1'b0; wr = 1'b0; rst = 1'b0;
    #1;
    if (readdatavalid !== 1'b0) begin fail_cnt++; $display("FAIL mid_rdv got %b, required 0", readdatavalid); end else pass_cnt++;
    if (ctrl_out !== 8'h0) begin fail_cnt++; $display("FAIL mid_ctrl got %h, required 0", ctrl_out); end else pass_cnt++;
    if (err_out !== 2'b00) begin fail_cnt++; $display("FAIL mid_err got %b, required 00", err_out); end else pass_cnt++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    repeat (8) @(negedge clk);
    #1;
    if (rsp_q.size() != 0) begin fail_cnt++; $display("FAIL mid_stale got %0d responses, required 0", rsp_q.size()); end else pass_cnt++;
    rsp_q.delete();
    xfer(1, 0, 20'h01000, 0, 4'hF, 32'h100);
    xfer(1, 0, 20'h00004, 0, 4'hF, 32'h0);
    idle();
    wait_rsp(ok);
    if (!ok) begin fail_cnt++; $display("FAIL post_count got %0d, required %0d", rsp_q.size(), exp_q.size()); end else pass_cnt++;
    while (exp_q.size() > 0 && rsp_q.size() > 0) begin
      e = exp_q.pop_front(); r = rsp_q.pop_front();
      if (r.d !== e.d || r.c - e.c != LAT) begin fail_cnt++; $display("FAIL post_rsp got %h lat %0d, required %h lat %0d", r.d, r.c - e.c, e.d, LAT); end else pass_cnt++;
    end
    exp_q.delete(); rsp_q.delete();
  endtask

  initial begin
    test_reset();
    test_scratch();
    test_back_to_back();
    test_err();
    test_freeze();
    test_perf();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule
